nexys_starship_repair_console: RTL and testbench
================================================

Name: nexys_starship_repair_console

Overview:
- Player-facing end of the room repair handshake.
- On a break request it draws a pseudo-random 4-bit target code for the SSD. It then samples the player's switch entry on a debounced BtnU press and compares entry against target.
- Issues a one-cycle repair_ok pulse back to the room controller, or raises fail after too many wrong attempts or a timeout.
- Sits between the Nexys switches/buttons and each room FSM; one instance per room.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: raw button must be stable this many Clk cycles before the debounced level changes.
- MAX_ATTEMPTS, 2'd3: wrong submissions allowed before fail.
- TIMEOUT_CYCLES, 32'd500000000: ARMED cycles allowed before fail (only with REPAIR_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- play_flag  in  1  game running; low forces IDLE
- gameover_ctrl  in  1  global game over; forces IDLE next cycle
- break_req  in  1  room has broken (level); arms console on rising edge
- sw  in  4  player's hex entry from switches
- BtnU  in  1  raw, asynchronous submit button
- random_hex  out  4  target code to display; valid while code_valid
- hex_combo  out  4  last submitted entry
- code_valid  out  1  high in ARMED and CHECK
- submit  out  1  one-cycle pulse per debounced BtnU press
- repair_ok  out  1  one-cycle pulse on correct entry
- attempts  out  2  wrong submissions in current repair
- fail  out  1  high in FAIL state

Behaviour:
- Reset (Reset==0, async) values:
  - state=IDLE; random_hex=0; hex_combo=0; code_valid=0; submit=0; repair_ok=0; attempts=0; fail=0.
  - LFSR=8'hA5; debounce counter=0; debounced level=0; synchronizer flops=0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle including IDLE, never zero.
- BtnU path:
  - 2-flop synchronizer feeds a counter.
  - Counter clears whenever the synced value equals the debounced level; otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - submit = debounced rising edge, exactly one cycle. Latency from a stable raw press to submit = 2 + DEBOUNCE_CYCLES cycles.
- break_req edge: a registered copy of break_req is kept; a rising edge is break_req & ~prev.
- FSM:
  - IDLE: outputs quiet. A break_req rising edge with play_flag=1 -> ARMED.
    - Same cycle: random_hex <= LFSR[3:0], with 4'h0 replaced by 4'hA so all-off switches never match. attempts <= 0.
  - ARMED: on submit, hex_combo <= sw, then -> CHECK.
  - CHECK, one cycle:
    - hex_combo==random_hex: repair_ok=1 for this cycle, -> IDLE.
    - Mismatch with attempts==MAX_ATTEMPTS-1: attempts increments, -> FAIL.
    - Other mismatch: attempts increments, -> ARMED.
  - FAIL: fail=1. Hold until gameover_ctrl or play_flag=0.
- Priority every cycle:
  - 1. gameover_ctrl or !play_flag: -> IDLE next cycle. code_valid and fail drop; attempts and random_hex retain their values. repair_ok is suppressed even if CHECK would match.
  - 2. Normal transitions.
- Simultaneous events:
  - break_req rising edge while not IDLE is ignored (no re-draw).
  - break_req falling while ARMED does not disarm.
  - submit while IDLE or FAIL is ignored.
  - submit during CHECK is dropped; the press is lost.
- attempts saturates at 3.
- Reset mid-operation returns to IDLE; any pending submit or repair_ok is lost.

Optional Feature:
- Macro REPAIR_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to ARMED and increments in ARMED and CHECK.
  - Reaching TIMEOUT_CYCLES-1 while ARMED -> FAIL. Timeout has lower priority than a same-cycle submit.
- Undefined: no counter, no TIMEOUT_CYCLES logic, ARMED waits indefinitely.

Decomposition:
- Shared package nexys_starship_pkg:
  - State localparams IDLE/ARMED/CHECK/FAIL, one-hot 4'b0001/0010/0100/1000.
  - LFSR seed 8'hA5 and tap mask.
  - Zero-code substitute 4'hA.
- One sub-module: nexys_starship_debounce (synchronizer + counter + rising-edge pulse), reused for BtnL/BtnR/BtnD elsewhere.

Test Plan (bench uses DEBOUNCE_CYCLES=4, MAX_ATTEMPTS=3, TIMEOUT_CYCLES=20):
- Reset low 3 cycles, release, play_flag=1, pulse break_req -> code_valid=1 next cycle; random_hex = mapped LFSR[3:0] at the edge; never 0.
- ARMED with random_hex=R, sw=R, hold BtnU 10 cycles -> single submit 6 cycles after press; repair_ok pulse next cycle; code_valid=0.
- Three presses with sw=R^4'h1 -> attempts 1,2,3; fail=1 after third CHECK; further presses no effect; gameover_ctrl=1 -> IDLE, fail=0.
- BtnU toggling every 2 cycles for 20 cycles -> zero submit pulses; then held stable -> exactly one.
- Matching submit with gameover_ctrl=1 in the CHECK cycle -> no repair_ok; IDLE next cycle.
- REPAIR_TIMEOUT_EN defined, armed, no press for 20 cycles -> fail=1. Undefined, 100 idle cycles -> still ARMED, fail=0.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// Shared state encoding, LFSR constants and helpers for the starship repair console.
package nexys_starship_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      ARMED = 4'b0010,
      CHECK = 4'b0100,
      FAIL  = 4'b1000
   } state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [3:0] ZERO_SUB  = 4'hA;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

   // All-off switches must never match, so code 0 is replaced.
   function automatic logic [3:0] map_code(input logic [3:0] raw);
      return (raw == 4'h0) ? ZERO_SUB : raw;
   endfunction

endpackage

// File: rtl/nexys_starship_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and one-cycle
// pulse on each debounced rising edge.
module nexys_starship_debounce #(
   parameter logic [15:0] CYCLES = 16'd50000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic raw,
   output logic rise
);

   logic        sync1;
   logic        sync2;
   logic        level;
   logic [15:0] cnt;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CYCLES - 16'd1) begin
            level <= sync2;
            cnt   <= '0;
            rise  <= sync2;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/nexys_starship_repair_console.sv
// Player-side repair handshake for one room: draws a target code, checks
// switch entries on BtnU and reports repair_ok or fail.
// Optional macro REPAIR_TIMEOUT_EN adds an ARMED timeout.
module nexys_starship_repair_console
   import nexys_starship_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [1:0]  MAX_ATTEMPTS    = 2'd3
`ifdef REPAIR_TIMEOUT_EN
   ,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
`endif
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       gameover_ctrl,
   input  logic       break_req,
   input  logic [3:0] sw,
   input  logic       BtnU,
   output logic [3:0] random_hex,
   output logic [3:0] hex_combo,
   output logic       code_valid,
   output logic       submit,
   output logic       repair_ok,
   output logic [1:0] attempts,
   output logic       fail
);

   state_t     state;
   state_t     state_n;
   logic [7:0] lfsr;
   logic       break_prev;
   logic       break_rise;
   logic       abort;
   logic       load_code;
   logic       load_combo;
   logic       bump_attempts;
`ifdef REPAIR_TIMEOUT_EN
   logic [31:0] tcnt;
`endif

   assign break_rise = break_req & ~break_prev;
   assign abort      = gameover_ctrl | ~play_flag;
   assign code_valid = (state == ARMED) || (state == CHECK);
   assign fail       = (state == FAIL);

   nexys_starship_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
   ) u_btnu (
      .Clk  (Clk),
      .Reset(Reset),
      .raw  (BtnU),
      .rise (submit)
   );

   always_comb begin
      state_n       = state;
      load_code     = 1'b0;
      load_combo    = 1'b0;
      bump_attempts = 1'b0;
      repair_ok     = 1'b0;
      // Abort outranks every normal transition, including a matching CHECK.
      if (abort) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (break_rise) begin
                  state_n   = ARMED;
                  load_code = 1'b1;
               end
            end
            ARMED: begin
               if (submit) begin
                  load_combo = 1'b1;
                  state_n    = CHECK;
               end
`ifdef REPAIR_TIMEOUT_EN
               else if (tcnt == TIMEOUT_CYCLES - 32'd1) begin
                  state_n = FAIL;
               end
`endif
            end
            CHECK: begin
               if (hex_combo == random_hex) begin
                  repair_ok = 1'b1;
                  state_n   = IDLE;
               end else begin
                  bump_attempts = 1'b1;
                  state_n = (attempts == MAX_ATTEMPTS - 2'd1) ? FAIL : ARMED;
               end
            end
            FAIL:    state_n = FAIL;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         break_prev <= 1'b0;
         random_hex <= '0;
         hex_combo  <= '0;
         attempts   <= '0;
      end else begin
         state      <= state_n;
         lfsr       <= lfsr_next(lfsr);
         break_prev <= break_req;
         if (load_code) begin
            random_hex <= map_code(lfsr[3:0]);
            attempts   <= '0;
         end
         if (load_combo) begin
            hex_combo <= sw;
         end
         if (bump_attempts && (attempts != 2'd3)) begin
            attempts <= attempts + 2'd1;
         end
      end
   end

`ifdef REPAIR_TIMEOUT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         tcnt <= '0;
      end else if ((state_n == ARMED) && (state != ARMED)) begin
         tcnt <= '0;
      end else if ((state == ARMED) || (state == CHECK)) begin
         tcnt <= tcnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nexys_starship_repair_console.sv
// Directed self-checking bench for nexys_starship_repair_console.
module tb_nexys_starship_repair_console;

   logic       Clk;
   logic       Reset;
   logic       play_flag;
   logic       gameover_ctrl;
   logic       break_req;
   logic [3:0] sw;
   logic       BtnU;
   logic [3:0] random_hex;
   logic [3:0] hex_combo;
   logic       code_valid;
   logic       submit;
   logic       repair_ok;
   logic [1:0] attempts;
   logic       fail;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] m_lfsr;
   logic [3:0] code;

   nexys_starship_repair_console #(
      .DEBOUNCE_CYCLES(16'd4),
      .MAX_ATTEMPTS   (2'd3)
`ifdef REPAIR_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (32'd20)
`endif
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .play_flag    (play_flag),
      .gameover_ctrl(gameover_ctrl),
      .break_req    (break_req),
      .sw           (sw),
      .BtnU         (BtnU),
      .random_hex   (random_hex),
      .hex_combo    (hex_combo),
      .code_valid   (code_valid),
      .submit       (submit),
      .repair_ok    (repair_ok),
      .attempts     (attempts),
      .fail         (fail)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, shifts every cycle out of reset.
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) m_lfsr <= 8'hA5;
      else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Raise break_req for one cycle; returns the code the DUT should draw.
   task automatic arm(output logic [3:0] exp_code);
      exp_code  = (m_lfsr[3:0] == 4'h0) ? 4'hA : m_lfsr[3:0];
      break_req = 1'b1;
      @(negedge Clk);
      break_req = 1'b0;
   endtask

   task automatic go_idle();
      gameover_ctrl = 1'b1;
      @(negedge Clk);
      gameover_ctrl = 1'b0;
   endtask

   // Hold BtnU for `hold` cycles then release for 8; records pulse positions.
   task automatic press_observe(input int hold, output int first_sub, output int n_sub,
                                output int first_ok, output int n_ok);
      first_sub = -1; n_sub = 0; first_ok = -1; n_ok = 0;
      BtnU = 1'b1;
      for (int i = 1; i <= hold + 8; i++) begin
         if (i == hold + 1) BtnU = 1'b0;
         @(negedge Clk);
         if (submit === 1'b1) begin
            n_sub++;
            if (first_sub < 0) first_sub = i;
         end
         if (repair_ok === 1'b1) begin
            n_ok++;
            if (first_ok < 0) first_ok = i;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; play_flag = 1'b0; gameover_ctrl = 1'b0;
      break_req = 1'b0; sw = 4'h0; BtnU = 1'b0;
      tick(3);
      n_checks++; if (random_hex !== 4'h0) $display("FAIL reset_random_hex got=%h want=0", random_hex); else n_pass++;
      n_checks++; if (hex_combo !== 4'h0) $display("FAIL reset_hex_combo got=%h want=0", hex_combo); else n_pass++;
      n_checks++; if (code_valid !== 1'b0) $display("FAIL reset_code_valid got=%b want=0", code_valid); else n_pass++;
      n_checks++; if (submit !== 1'b0) $display("FAIL reset_submit got=%b want=0", submit); else n_pass++;
      n_checks++; if (repair_ok !== 1'b0) $display("FAIL reset_repair_ok got=%b want=0", repair_ok); else n_pass++;
      n_checks++; if (attempts !== 2'd0) $display("FAIL reset_attempts got=%0d want=0", attempts); else n_pass++;
      n_checks++; if (fail !== 1'b0) $display("FAIL reset_fail got=%b want=0", fail); else n_pass++;
      Reset = 1'b1;
      play_flag = 1'b1;
      tick(2);
   endtask

   task automatic test_idle_press();
      int fs, ns, fo, no;
      sw = 4'h7;
      press_observe(10, fs, ns, fo, no);
      n_checks++; if (ns !== 1) $display("FAIL idle_submit_count got=%0d want=1", ns); else n_pass++;
      n_checks++; if (no !== 0) $display("FAIL idle_repair_ok_count got=%0d want=0", no); else n_pass++;
      n_checks++; if (hex_combo !== 4'h0) $display("FAIL idle_hex_combo got=%h want=0", hex_combo); else n_pass++;
      n_checks++; if (code_valid !== 1'b0) $display("FAIL idle_code_valid got=%b want=0", code_valid); else n_pass++;
   endtask

   task automatic test_arm();
      arm(code);
      n_checks++; if (code_valid !== 1'b1) $display("FAIL arm_code_valid got=%b want=1", code_valid); else n_pass++;
      n_checks++; if (random_hex !== code) $display("FAIL arm_random_hex got=%h want=%h", random_hex, code); else n_pass++;
      n_checks++; if (random_hex === 4'h0) $display("FAIL arm_nonzero got=%h want=nonzero", random_hex); else n_pass++;
      // second rising edge while ARMED must not redraw; falling edge must not disarm
      tick(1);
      break_req = 1'b1;
      tick(2);
      break_req = 1'b0;
      n_checks++; if (random_hex !== code) $display("FAIL rearm_random_hex got=%h want=%h", random_hex, code); else n_pass++;
      n_checks++; if (code_valid !== 1'b1) $display("FAIL rearm_code_valid got=%b want=1", code_valid); else n_pass++;
   endtask

   task automatic test_correct();
      int fs, ns, fo, no;
      sw = code;
      press_observe(10, fs, ns, fo, no);
      n_checks++; if (fs !== 6) $display("FAIL correct_submit_latency got=%0d want=6", fs); else n_pass++;
      n_checks++; if (ns !== 1) $display("FAIL correct_submit_count got=%0d want=1", ns); else n_pass++;
      n_checks++; if (fo !== 7) $display("FAIL correct_ok_cycle got=%0d want=7", fo); else n_pass++;
      n_checks++; if (no !== 1) $display("FAIL correct_ok_count got=%0d want=1", no); else n_pass++;
      n_checks++; if (code_valid !== 1'b0) $display("FAIL correct_code_valid got=%b want=0", code_valid); else n_pass++;
      n_checks++; if (hex_combo !== code) $display("FAIL correct_hex_combo got=%h want=%h", hex_combo, code); else n_pass++;
   endtask

   task automatic test_fail();
      int fs, ns, fo, no;
      arm(code);
      sw = code ^ 4'h1;
      for (int k = 1; k <= 3; k++) begin
         press_observe(8, fs, ns, fo, no);
         n_checks++; if (attempts !== 2'(k)) $display("FAIL wrong_attempts_%0d got=%0d want=%0d", k, attempts, k); else n_pass++;
         n_checks++; if (no !== 0) $display("FAIL wrong_ok_%0d got=%0d want=0", k, no); else n_pass++;
      end
      n_checks++; if (fail !== 1'b1) $display("FAIL fail_raised got=%b want=1", fail); else n_pass++;
      n_checks++; if (code_valid !== 1'b0) $display("FAIL fail_code_valid got=%b want=0", code_valid); else n_pass++;
      sw = code;
      press_observe(8, fs, ns, fo, no);
      n_checks++; if (attempts !== 2'd3) $display("FAIL fail_hold_attempts got=%0d want=3", attempts); else n_pass++;
      n_checks++; if (fail !== 1'b1) $display("FAIL fail_hold got=%b want=1", fail); else n_pass++;
      n_checks++; if (no !== 0) $display("FAIL fail_press_ok got=%0d want=0", no); else n_pass++;
      go_idle();
      n_checks++; if (fail !== 1'b0) $display("FAIL gameover_fail got=%b want=0", fail); else n_pass++;
      n_checks++; if (attempts !== 2'd3) $display("FAIL gameover_attempts got=%0d want=3", attempts); else n_pass++;
      n_checks++; if (random_hex !== code) $display("FAIL gameover_random_hex got=%h want=%h", random_hex, code); else n_pass++;
   endtask

   task automatic test_bounce();
      int ns = 0;
      int fs, fo, no;
      arm(code);
      n_checks++; if (attempts !== 2'd0) $display("FAIL rearm_attempts_clear got=%0d want=0", attempts); else n_pass++;
      sw = code;
      for (int i = 0; i < 20; i++) begin
         if ((i % 2) == 0) BtnU = ~BtnU;
         @(negedge Clk);
         if (submit === 1'b1) ns++;
      end
      BtnU = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (submit === 1'b1) ns++;
      end
      n_checks++; if (ns !== 0) $display("FAIL bounce_submit_count got=%0d want=0", ns); else n_pass++;
      press_observe(10, fs, ns, fo, no);
      n_checks++; if (ns !== 1) $display("FAIL stable_submit_count got=%0d want=1", ns); else n_pass++;
      go_idle();
   endtask

   task automatic test_abort();
      arm(code);
      sw = code;
      BtnU = 1'b1;
      tick(7);
      gameover_ctrl = 1'b1;
      #1;
      n_checks++; if (code_valid !== 1'b1) $display("FAIL abort_in_check got=%b want=1", code_valid); else n_pass++;
      n_checks++; if (repair_ok !== 1'b0) $display("FAIL abort_ok_suppressed got=%b want=0", repair_ok); else n_pass++;
      @(negedge Clk);
      n_checks++; if (code_valid !== 1'b0) $display("FAIL abort_idle got=%b want=0", code_valid); else n_pass++;
      n_checks++; if (repair_ok !== 1'b0) $display("FAIL abort_ok_after got=%b want=0", repair_ok); else n_pass++;
      gameover_ctrl = 1'b0;
      BtnU = 1'b0;
      tick(8);
   endtask

   task automatic test_timeout();
      arm(code);
`ifdef REPAIR_TIMEOUT_EN
      tick(19);
      n_checks++; if (fail !== 1'b0) $display("FAIL timeout_early got=%b want=0", fail); else n_pass++;
      tick(1);
      n_checks++; if (fail !== 1'b1) $display("FAIL timeout_fail got=%b want=1", fail); else n_pass++;
`else
      tick(100);
      n_checks++; if (code_valid !== 1'b1) $display("FAIL no_timeout_armed got=%b want=1", code_valid); else n_pass++;
      n_checks++; if (fail !== 1'b0) $display("FAIL no_timeout_fail got=%b want=0", fail); else n_pass++;
`endif
      play_flag = 1'b0;
      @(negedge Clk);
      n_checks++; if (code_valid !== 1'b0) $display("FAIL play_low_idle got=%b want=0", code_valid); else n_pass++;
      n_checks++; if (fail !== 1'b0) $display("FAIL play_low_fail got=%b want=0", fail); else n_pass++;
      play_flag = 1'b1;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_idle_press();
      test_arm();
      test_correct();
      test_fail();
      test_bounce();
      test_abort();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
